multicycle_sequencer: RTL

//  Multi-cycle control FSM for the RV32 datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Per state it drives the datapath strobes: RegWrite, ALU_Src, MemRead, MemWrite, MemToReg, Branch, ALU_Op.

---
 rtl/rv_ctrl_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control path.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        NONE,
        R,
        I,
        LOAD,
        STORE,
        BRANCH,
        ILL
    } instr_class_t;

    // Map the 7-bit major opcode onto an instruction class.
    function automatic instr_class_t decode_class(input logic [6:0] op);
        instr_class_t c;
        case (op)
            OP_R:      c = R;
            OP_I:      c = I;
            OP_LOAD:   c = LOAD;
            OP_STORE:  c = STORE;
            OP_BRANCH: c = BRANCH;
            default:   c = ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without mem_ready; flags the abort cycle.
// Latency: timeout is combinational, asserted in the MEM_TIMEOUT-th unanswered request cycle.
// Backpressure: none; the count restarts whenever the request is answered, dropped or aborted.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic ready,
    output logic timeout
);
    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    // Number of unanswered request cycles already elapsed in the current access.
    logic [W-1:0] count;

    // The count holds elapsed waits, so the compare against MEM_TIMEOUT-1 fires on the
    // cycle that would make the total reach MEM_TIMEOUT.
    assign timeout = waiting && !ready && (count == LAST);

    // Clear outside a pending access (covers entry into FETCH/MEM), otherwise count waits.
    always_ff @(posedge clk) begin
        if (rst || !waiting || ready || timeout) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with datapath strobes and retire count.
// Latency (zero-wait memory): BRANCH 3, R/I/STORE 4, LOAD 5 cycles.
// Backpressure: stalls in FETCH/MEM until mem_ready; aborts the access after MEM_TIMEOUT waits.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter bit HALT_ON_ILL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             RegWrite,
    output logic             ALU_Src,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             Branch,
    output logic [1:0]       ALU_Op,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted
);

    seq_state_t   state;
    seq_state_t   state_nxt;
    instr_class_t cls;
    instr_class_t dec_cls;
    logic         tmo;

    // ALU controls for a class; WB keeps them so the ALU result stays valid while written back.
    function automatic logic [2:0] alu_fields(input instr_class_t c);
        logic [2:0] f;
        case (c)
            R:           f = {ALU_RTYPE, 1'b0};
            I:           f = {ALU_ITYPE, 1'b1};
            LOAD, STORE: f = {ALU_ADD,   1'b1};
            BRANCH:      f = {ALU_BR,    1'b0};
            default:     f = {ALU_ADD,   1'b0};
        endcase
        return f;
    endfunction

    assign dec_cls = decode_class(opcode);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (mem_req),
        .ready   (mem_ready),
        .timeout (tmo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the instruction class once the IR is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cls <= NONE;
        end else if (state == DECODE) begin
            cls <= dec_cls;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // Next state plus strobe decode; strobes come from state/class, handshake pulses from mem_ready.
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        RegWrite     = 1'b0;
        ALU_Src      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemToReg     = 1'b0;
        Branch       = 1'b0;
        ALU_Op       = ALU_ADD;
        retire       = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        halted       = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = DECODE;
                end else if (tmo) begin
                    // PC is left alone so the same word is fetched again.
                    bus_err   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DECODE: begin
                if (dec_cls == ILL) begin
                    illegal   = 1'b1;
                    state_nxt = HALT_ON_ILL ? HALT : FETCH;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                {ALU_Op, ALU_Src} = alu_fields(cls);
                case (cls)
                    R, I:        state_nxt = WB;
                    LOAD, STORE: state_nxt = MEM;
                    BRANCH: begin
                        Branch    = 1'b1;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                    default:     state_nxt = FETCH;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                ALU_Op       = ALU_ADD;
                ALU_Src      = 1'b1;
                MemRead      = (cls == LOAD);
                MemWrite     = (cls == STORE);
                if (mem_ready) begin
                    if (cls == LOAD) begin
                        state_nxt = WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (tmo) begin
                    bus_err   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            WB: begin
                {ALU_Op, ALU_Src} = alu_fields(cls);
                RegWrite  = 1'b1;
                MemToReg  = (cls == LOAD);
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        // Nothing leaves the block during a reset cycle, whatever state it interrupts.
        if (rst) begin
            mem_req      = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            RegWrite     = 1'b0;
            ALU_Src      = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            MemToReg     = 1'b0;
            Branch       = 1'b0;
            ALU_Op       = ALU_ADD;
            retire       = 1'b0;
            illegal      = 1'b0;
            bus_err      = 1'b0;
            halted       = 1'b0;
        end
    end

endmodule
